// File: rtl/traffic_pkg.sv
// Shared codes and helpers for the N-way traffic controller.
// Lamp and phase encodings keep the legacy two-road values.
package traffic_pkg;

  typedef enum logic [1:0] {
    R = 2'd0,
    Y = 2'd1,
    G = 2'd2
  } light_e;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_YELLOW = 2'd1,
    PH_GREEN  = 2'd2
  } phase_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin picker: first set request at or after start_i,
// wrapping modulo NUM_DIR.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR = 2,
  localparam int DW      = clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] req_i,
  input  logic [DW-1:0]      start_i,
  output logic               found_o,
  output logic [DW-1:0]      idx_o
);

  logic [2*NUM_DIR-1:0] dbl;
  logic [DW:0]          sum;

  assign dbl = {req_i, req_i} >> start_i;

  // Scan from the far end so the nearest offset wins.
  always_comb begin
    found_o = 1'b0;
    sum     = '0;
    for (int k = NUM_DIR - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, start_i} + (DW+1)'(k);
      end
    end
    if (sum >= (DW+1)'(NUM_DIR)) idx_o = DW'(sum - (DW+1)'(NUM_DIR));
    else                         idx_o = DW'(sum);
  end

endmodule

// File: rtl/traffic_con_nway.sv
// N-approach round-robin traffic controller with latched demand,
// min/max green, yellow and optional all-red clearance.
module traffic_con_nway
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR   = 2,
  parameter  int REST_DIR  = 0,
  parameter  int MIN_GREEN = 6,
  parameter  int MAX_GREEN = 16,
  parameter  int YELLOW_T  = 1,
  parameter  int ALLRED_T  = 0,
  localparam int DW        = clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] sense,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DW-1:0]      cur_dir,
  output logic [1:0]         phase,
  output logic [NUM_DIR-1:0] pending
);

  localparam int TM0  = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int TMAX = (TM0 > ALLRED_T) ? TM0 : ALLRED_T;
  localparam int TW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);

  localparam logic [TW-1:0] T_SAT  = TW'(TMAX - 1);
  localparam logic [TW:0]   T_MING = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   T_MAXG = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0]   T_YEL  = (TW+1)'(YELLOW_T);
  localparam logic [TW:0]   T_AR   = (TW+1)'((ALLRED_T == 0) ? 1 : ALLRED_T);
  localparam logic [DW-1:0] REST   = DW'(REST_DIR);
  localparam logic [NUM_DIR-1:0] REST_OH = NUM_DIR'(1) << REST_DIR;

  if (NUM_DIR < 2) begin : g_chk_nd
    $error("NUM_DIR must be >= 2");
  end
  if (REST_DIR < 0 || REST_DIR >= NUM_DIR) begin : g_chk_rest
    $error("REST_DIR out of range");
  end
  if (MIN_GREEN < 1) begin : g_chk_min
    $error("MIN_GREEN must be >= 1");
  end
  if (MAX_GREEN < MIN_GREEN) begin : g_chk_max
    $error("MAX_GREEN must be >= MIN_GREEN");
  end
  if (YELLOW_T < 1) begin : g_chk_y
    $error("YELLOW_T must be >= 1");
  end
  if (ALLRED_T < 0) begin : g_chk_ar
    $error("ALLRED_T must be >= 0");
  end

  phase_e             phase_q, phase_d;
  logic [DW-1:0]      cur_q, cur_d;
  logic [DW-1:0]      nxt_q, nxt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_DIR-1:0] req_q, req_d;
  logic [NUM_DIR-1:0] red_q, red_d;
  logic [NUM_DIR-1:0] yel_q, yel_d;
  logic [NUM_DIR-1:0] grn_q, grn_d;

  logic [NUM_DIR-1:0] oh_cur, oh_nxt, other;
  logic [DW-1:0]      rr_start, rr_idx;
  logic               rr_found, own, go_green;
  logic [TW:0]        tel;

  assign oh_cur   = NUM_DIR'(1) << cur_q;
  assign oh_nxt   = NUM_DIR'(1) << nxt_q;
  assign own      = |(sense & oh_cur);
  assign other    = (req_q | sense) & ~oh_cur;
  assign rr_start = (cur_q == DW'(NUM_DIR - 1)) ? '0 : cur_q + DW'(1);
  // Cycles spent in the current phase, including this one.
  assign tel      = {1'b0, timer_q} + (TW+1)'(1);

  traffic_rr_pick #(
    .NUM_DIR (NUM_DIR)
  ) u_pick (
    .req_i   (other),
    .start_i (rr_start),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

  always_comb begin
    phase_d  = phase_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    timer_d  = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
    req_d    = (req_q | sense) & ~((phase_q == PH_GREEN) ? oh_cur : '0);
    go_green = 1'b0;
    unique case (phase_q)
      PH_GREEN: begin
        if (tel >= T_MING &&
            ((|other && (!own || tel >= T_MAXG)) ||
             (cur_q != REST && !own))) begin
          phase_d = PH_YELLOW;
          timer_d = '0;
          nxt_d   = rr_found ? rr_idx : REST;
        end
      end
      PH_YELLOW: begin
        if (tel >= T_YEL) begin
          if (ALLRED_T == 0) begin
            go_green = 1'b1;
          end else begin
            phase_d = PH_ALLRED;
            timer_d = '0;
          end
        end
      end
      PH_ALLRED: begin
        if (tel >= T_AR) go_green = 1'b1;
      end
      default: go_green = 1'b1;
    endcase
    if (go_green) begin
      phase_d = PH_GREEN;
      cur_d   = nxt_q;
      timer_d = '0;
      req_d   = req_d & ~oh_nxt;
    end
    grn_d = (phase_d == PH_GREEN)  ? (NUM_DIR'(1) << cur_d) : '0;
    yel_d = (phase_d == PH_YELLOW) ? (NUM_DIR'(1) << cur_d) : '0;
    red_d = ~(grn_d | yel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      cur_q   <= REST;
      nxt_q   <= REST;
      timer_q <= '0;
      req_q   <= '0;
      grn_q   <= REST_OH;
      yel_q   <= '0;
      red_q   <= ~REST_OH;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      grn_q   <= grn_d;
      yel_q   <= yel_d;
      red_q   <= red_d;
    end
  end

  assign red     = red_q;
  assign yellow  = yel_q;
  assign green   = grn_q;
  assign cur_dir = cur_q;
  assign phase   = phase_q;
  assign pending = req_q;

endmodule

// File: tb/tb_traffic_con_nway.sv
// Bench for traffic_con_nway: a 2-way default instance and a 4-way
// instance with all-red, both tracked by a cycle-level reference model.
module tb_traffic_con_nway;

  logic       clk;
  logic       rst;
  logic [1:0] sense2;
  logic [3:0] sense4;

  logic [1:0] red2, yel2, grn2, pend2;
  logic [0:0] cur2;
  logic [1:0] ph2;
  logic [3:0] red4, yel4, grn4, pend4;
  logic [1:0] cur4;
  logic [1:0] ph4;

  int checks   = 0;
  int failures = 0;
  int c        = 0;
  bit men      = 0;

  traffic_con_nway dut2 (
    .clk     (clk),
    .rst     (rst),
    .sense   (sense2),
    .red     (red2),
    .yellow  (yel2),
    .green   (grn2),
    .cur_dir (cur2),
    .phase   (ph2),
    .pending (pend2)
  );

  traffic_con_nway #(
    .NUM_DIR  (4),
    .ALLRED_T (2)
  ) dut4 (
    .clk     (clk),
    .rst     (rst),
    .sense   (sense4),
    .red     (red4),
    .yellow  (yel4),
    .green   (grn4),
    .cur_dir (cur4),
    .phase   (ph4),
    .pending (pend4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ph: 0 all-red, 1 yellow, 2 green; t = whole cycles already in phase
  typedef struct {
    int         ph;
    int         cur;
    int         nxt;
    int         t;
    logic [3:0] req;
  } ms_t;

  ms_t m2, m4;

  function automatic ms_t mstep(ms_t s, logic [3:0] sn, logic r, int n,
                                int mn, int mx, int yt, int ar, int rest);
    ms_t        o;
    logic [3:0] dem;
    bit         oth, own, got, enter;
    int         el, j;
    o = s;
    if (r) begin
      o.ph = 2; o.cur = rest; o.nxt = rest; o.t = 0; o.req = '0;
      return o;
    end
    dem = '0; oth = 0; got = 0; enter = 0;
    for (int i = 0; i < n; i++) begin
      dem[i] = s.req[i] | sn[i];
      if (dem[i] && i != s.cur) oth = 1;
      o.req[i] = (s.ph == 2 && i == s.cur) ? 1'b0 : dem[i];
    end
    own = sn[s.cur];
    el  = s.t + 1;
    o.t = s.t + 1;
    if (s.ph == 2) begin
      if (el >= mn && ((oth && (!own || el >= mx)) ||
                       (s.cur != rest && !own))) begin
        o.ph = 1; o.t = 0; o.nxt = rest;
        for (int k = 1; k < n; k++) begin
          j = (s.cur + k) % n;
          if (!got && dem[j]) begin
            o.nxt = j; got = 1;
          end
        end
      end
    end else if (s.ph == 1) begin
      if (el >= yt) begin
        if (ar == 0) enter = 1;
        else begin
          o.ph = 0; o.t = 0;
        end
      end
    end else begin
      if (el >= ar) enter = 1;
    end
    if (enter) begin
      o.ph = 2; o.cur = s.nxt; o.t = 0; o.req[s.nxt] = 1'b0;
    end
    return o;
  endfunction

  function automatic logic [31:0] mexp(ms_t s, int n);
    logic [3:0] g, y, r, msk;
    msk = 4'((1 << n) - 1);
    g = '0; y = '0;
    if (s.ph == 2) g = 4'(1 << s.cur);
    if (s.ph == 1) y = 4'(1 << s.cur);
    r = ~(g | y) & msk;
    return {10'b0, g, y, r, s.req & msk, 4'(s.cur), 2'(s.ph)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  task automatic tick(input logic [1:0] s2, input logic [3:0] s4,
                      input logic r);
    if (men) begin
      chk("model2", {10'b0, 2'b0, grn2, 2'b0, yel2, 2'b0, red2,
                     2'b0, pend2, 3'b0, cur2, ph2}, mexp(m2, 2));
      chk("model4", {10'b0, grn4, yel4, red4, pend4, 2'b0, cur4, ph4},
          mexp(m4, 4));
    end
    sense2 = s2;
    sense4 = s4;
    rst    = r;
    m2 = mstep(m2, {2'b00, s2}, r, 2, 6, 16, 1, 0, 0);
    m4 = mstep(m4, s4, r, 4, 6, 16, 1, 2, 0);
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic do_reset();
    tick(2'b00, 4'b0000, 1'b1);
    c   = 0;
    men = 1;
  endtask

  typedef struct {
    logic [1:0] s;
    logic [1:0] g;
    logic [1:0] y;
    logic [1:0] p;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [1:0] s2;
    logic [3:0] s4;
    int         dens;

    tbl[0]  = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[1]  = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[2]  = '{2'b10, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{2'b00, 2'b01, 2'b00, 2'b10};
    tbl[4]  = '{2'b00, 2'b01, 2'b00, 2'b10};
    tbl[5]  = '{2'b00, 2'b01, 2'b00, 2'b10};
    tbl[6]  = '{2'b00, 2'b00, 2'b01, 2'b10};
    tbl[7]  = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[8]  = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[9]  = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[10] = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[11] = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[12] = '{2'b00, 2'b10, 2'b00, 2'b00};
    tbl[13] = '{2'b00, 2'b00, 2'b10, 2'b00};
    tbl[14] = '{2'b00, 2'b01, 2'b00, 2'b00};
    tbl[15] = '{2'b00, 2'b01, 2'b00, 2'b00};

    rst    = 1'b1;
    sense2 = '0;
    sense4 = '0;

    // Idle: rest direction holds green.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      chk("idle2", {grn2, red2, yel2, ph2, 1'b0, cur2},
          {2'b01, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0});
      tick(2'b00, 4'b0000, 1'b0);
    end

    // Single pulse on approach 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("pulse_g", 32'(grn2), 32'(tbl[i].g));
      chk("pulse_y", 32'(yel2), 32'(tbl[i].y));
      chk("pulse_p", 32'(pend2), 32'(tbl[i].p));
      tick(tbl[i].s, 4'b0000, 1'b0);
    end

    // Both held: max green alternation with period 17.
    do_reset();
    for (int i = 0; i < 52; i++) begin
      chk("held_cur", 32'(cur2), 32'((i / 17) % 2));
      chk("held_y", 32'(|yel2), 32'(i % 17 == 16));
      tick(2'b11, 4'b0000, 1'b0);
    end

    // 4-way: 1 and 3 requested together -> 0,1,3,0.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 8)  chk("rr_g1_pre", 32'(grn4), 32'h0);
      if (i == 9)  chk("rr_g1", 32'(grn4), 32'h2);
      if (i == 18) chk("rr_g3", 32'(grn4), 32'h8);
      if (i == 27) chk("rr_g0", 32'(grn4), 32'h1);
      if (i == 7)  chk("rr_allred", 32'(red4), 32'hf);
      tick(2'b00, (i == 0) ? 4'b1010 : 4'b0000, 1'b0);
    end

    // 4-way: request 2 arrives during yellow while nxt is 1.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 6)  chk("ly_y0", 32'(yel4), 32'h1);
      if (i == 9)  chk("ly_g1", 32'(grn4), 32'h2);
      if (i == 7 || i == 17) chk("ly_p2", 32'(pend4[2]), 32'h1);
      if (i == 18) chk("ly_g2", 32'(grn4), 32'h4);
      if (i == 18) chk("ly_p2clr", 32'(pend4[2]), 32'h0);
      tick(2'b00, (i == 0) ? 4'b0010 : ((i == 6) ? 4'b0100 : 4'b0000),
           1'b0);
    end

    // Reset during yellow (cycle 15) or all-red (cycle 16) of approach 1.
    for (int rc = 15; rc <= 16; rc++) begin
      do_reset();
      for (int i = 0; i < rc + 9; i++) begin
        if (i == rc) chk("mr_ph", 32'(ph4), (rc == 15) ? 32'd1 : 32'd0);
        if (i == rc + 1) chk("mr_pend", 32'(pend4), 32'h0);
        if (i > rc && i <= rc + 6) chk("mr_g0", 32'(grn4), 32'h1);
        if (i == rc + 7) chk("mr_y0", 32'(yel4), 32'h1);
        s4 = (i == 0) ? 4'b0010 : ((i == rc + 1) ? 4'b0100 : 4'b0000);
        tick(2'b00, s4, (i == rc) ? 1'b1 : 1'b0);
      end
    end

    // Randomized traffic against the model.
    do_reset();
    s2   = '0;
    s4   = '0;
    dens = 4;
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) dens = $urandom_range(1, 10);
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 2; b++) s2[b] = ($urandom_range(1, dens) == 1);
        for (int b = 0; b < 4; b++) s4[b] = ($urandom_range(1, dens) == 1);
      end
      tick(s2, s4, ($urandom_range(0, 299) == 0));
    end
    tick(2'b00, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
